// File: rtl/down_counter_mod10_pkg.sv
// Shared constants and helpers for the mod-10 down counter.
package down_counter_mod10_pkg;

    localparam int CNT_W   = 4;
    localparam int MOD_MAX = 9;

    // Highest legal digit, sized to the count register.
    localparam logic [CNT_W-1:0] DIGIT_MAX = CNT_W'(MOD_MAX);

    // Tick-rate select encodings.
    localparam logic MODE_2HZ = 1'b0;
    localparam logic MODE_1HZ = 1'b1;

    // Out-of-range load values saturate at the top digit.
    function automatic logic [CNT_W-1:0] clamp_digit(input logic [CNT_W-1:0] v);
        return (v > DIGIT_MAX) ? DIGIT_MAX : v;
    endfunction

endpackage

// File: rtl/down_counter_mod10_tick.sv
// Prescaler: divides Clk down to a one-cycle Tick at 2 Hz or 1 Hz.
// A Mode change (seen against a registered copy) or Clr restarts the period.
module tick_gen
    import down_counter_mod10_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV_W  = 26
) (
    input  logic Clk,
    input  logic RST,
    input  logic Mode,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam logic [DIV_W-1:0] LAST_2HZ = DIV_W'(CLK_HZ / 2 - 1);
    localparam logic [DIV_W-1:0] LAST_1HZ = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;
    logic             mode_q;
    logic             armed;
    logic             mode_chg;
    logic             at_last;

    // The first edge after reset only captures Mode, so the registered copy
    // holds the Mode value present at release and no false change is seen.
    assign last     = (Mode == MODE_1HZ) ? LAST_1HZ : LAST_2HZ;
    assign mode_chg = armed && (Mode != mode_q);
    // >= covers a 1 Hz -> 2 Hz switch while cnt is above the new terminal.
    assign at_last  = (cnt >= last);
    assign Tick     = armed && En && at_last && !mode_chg && !Clr;

    // Prescaler count, Mode copy and post-reset arming.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            mode_q <= MODE_2HZ;
            armed  <= 1'b0;
        end else begin
            mode_q <= Mode;
            armed  <= 1'b1;
            if (Clr || mode_chg || !armed)
                cnt <= '0;
            else if (En)
                cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/down_counter_mod10.sv
// Decimal down counter 9..0 with wrap Borrow, clamped load and a 2/1 Hz prescaler.
module down_counter_mod10
    import down_counter_mod10_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV_W  = 26
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic             Mode,
    input  logic             En,
    input  logic             Load,
    input  logic [CNT_W-1:0] D,
    output logic [CNT_W-1:0] OUT,
    output logic             Borrow,
    output logic             Zero
);

    logic tick;

    // Load doubles as the prescaler clear so a loaded value gets a full period.
    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_tick (
        .Clk  (Clk),
        .RST  (RST),
        .Mode (Mode),
        .En   (En),
        .Clr  (Load),
        .Tick (tick)
    );

    // Digit register: load wins over tick; wrap 0 -> 9 raises Borrow for one cycle.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            OUT    <= DIGIT_MAX;
            Borrow <= 1'b0;
        end else begin
            Borrow <= 1'b0;
            if (Load) begin
                OUT <= clamp_digit(D);
            end else if (tick) begin
                if (OUT == '0) begin
                    OUT    <= DIGIT_MAX;
                    Borrow <= 1'b1;
                end else begin
                    OUT <= OUT - 1'b1;
                end
            end
        end
    end

    assign Zero = (OUT == '0);

endmodule

// File: tb/tb_down_counter_mod10.sv
// Directed bench for down_counter_mod10 with CLK_HZ=8 (DIV 4 / 8).
module tb_down_counter_mod10;

    localparam int CLK_HZ = 8;
    localparam int DIV_W  = 4;

    logic       Clk  = 1'b0;
    logic       RST  = 1'b1;
    logic       Mode = 1'b0;
    logic       En   = 1'b0;
    logic       Load = 1'b0;
    logic [3:0] D    = 4'd0;
    logic [3:0] OUT;
    logic       Borrow;
    logic       Zero;

    int n_chk  = 0;
    int n_pass = 0;

    down_counter_mod10 #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) dut (
        .Clk    (Clk),
        .RST    (RST),
        .Mode   (Mode),
        .En     (En),
        .Load   (Load),
        .D      (D),
        .OUT    (OUT),
        .Borrow (Borrow),
        .Zero   (Zero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Reset, then release; the next rising edge is the first active edge.
    task automatic do_reset(input logic m);
        RST  = 1'b1;
        Mode = m;
        En   = 1'b1;
        Load = 1'b0;
        D    = 4'd0;
        cyc(1);
        chk("rst out", OUT, 9);
        chk("rst borrow", Borrow, 0);
        chk("rst zero", Zero, 0);
        RST = 1'b0;
    endtask

    initial begin
        int idx;
        int e;

        // Count-down at 2 Hz: 9..0 then wrap to 9, each value 4 edges.
        do_reset(1'b0);
        for (int k = 1; k <= 44; k++) begin
            cyc(1);
            idx = (k - 1) / 4;
            e   = 9 - (idx % 10);
            chk("t1 out", OUT, e);
            chk("t1 borrow", Borrow, (k > 1 && (k - 1) % 4 == 0 && idx % 10 == 0) ? 1 : 0);
            chk("t1 zero", Zero, (e == 0) ? 1 : 0);
        end

        // 1 Hz rate: each value 8 edges.
        do_reset(1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk("t2 out", OUT, 9 - (k - 1) / 8);
            chk("t2 borrow", Borrow, 0);
        end
        // Prescaler at 3 now; switching to 2 Hz must restart, not tick.
        Mode = 1'b0;
        for (int k = 21; k <= 25; k++) begin
            cyc(1);
            chk("t2 toggle out", OUT, (k < 25) ? 7 : 6);
        end

        // Load D=3, then decrement after a full period.
        do_reset(1'b0);
        cyc(2);
        Load = 1'b1; D = 4'd3;
        cyc(1);
        chk("t3 load out", OUT, 3);
        chk("t3 load borrow", Borrow, 0);
        Load = 1'b0;
        cyc(3);
        chk("t3 hold out", OUT, 3);
        cyc(1);
        chk("t3 dec out", OUT, 2);

        // Clamp: D=12 loads as 9.
        Load = 1'b1; D = 4'd12;
        cyc(1);
        chk("t3 clamp out", OUT, 9);
        chk("t3 clamp borrow", Borrow, 0);

        // Load coincident with a pending tick at OUT=0.
        D = 4'd0;
        cyc(1);
        Load = 1'b0;
        chk("t3 zero out", OUT, 0);
        chk("t3 zero flag", Zero, 1);
        cyc(3);
        chk("t3 pending out", OUT, 0);
        Load = 1'b1; D = 4'd5;
        cyc(1);
        Load = 1'b0;
        chk("t3 coinc out", OUT, 5);
        chk("t3 coinc borrow", Borrow, 0);
        chk("t3 coinc zero", Zero, 0);

        // Enable hold mid-period at OUT=5 (prescaler at 2).
        cyc(2);
        En = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("t4 hold out", OUT, 5);
        end
        En = 1'b1;
        cyc(1);
        chk("t4 resume out", OUT, 5);
        cyc(1);
        chk("t4 dec out", OUT, 4);
        chk("t4 dec borrow", Borrow, 0);

        // Asynchronous reset while OUT=0 and a tick is pending.
        do_reset(1'b0);
        Load = 1'b1; D = 4'd0;
        cyc(1);
        Load = 1'b0;
        cyc(3);
        chk("t5 pending zero", Zero, 1);
        #2 RST = 1'b1;
        #1;
        chk("t5 async out", OUT, 9);
        chk("t5 async borrow", Borrow, 0);
        chk("t5 async zero", Zero, 0);
        cyc(1);
        RST = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk("t5 restart out", OUT, (k < 5) ? 9 : 8);
        end

        // Asynchronous reset truncates a Borrow pulse.
        Load = 1'b1; D = 4'd0;
        cyc(1);
        Load = 1'b0;
        cyc(4);
        chk("t5 wrap out", OUT, 9);
        chk("t5 wrap borrow", Borrow, 1);
        #2 RST = 1'b1;
        #1;
        chk("t5 trunc borrow", Borrow, 0);
        chk("t5 trunc out", OUT, 9);
        cyc(1);
        RST = 1'b0;
        cyc(2);
        chk("t5 post borrow", Borrow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
